bram_arbiter: RTL and testbench

//   Shares the single-port MCU block RAM between the instruction-fetch port (I) and the load/store port (D).

---
 rtl/bram_arbiter.sv | 137 +++++++++++++
 tb/tb_bram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Shares one single-port block RAM between the fetch (I) and load/store (D) ports.
// One RAM access per cycle; partial-word stores become a two-cycle read-modify-write.
module bram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_en,
    output logic                  m_rd_en,
    output logic                  m_wr_en,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  dbg_state_o
);
    localparam int NB = DATA_W / 8;

    // Handshake: a port holds req and operands stable until its gnt; gnt marks the
    // cycle the access is issued (or, for a partial store, the cycle its write is issued).
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;     // 1 = D won the most recent grant
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              pick_i, pick_d;
    logic [DATA_W-1:0] merged;

    assign i_rdata     = m_rdata;
    assign d_rdata     = m_rdata;
    assign i_rvalid    = i_rvalid_q & ~rst;
    assign d_rvalid    = d_rvalid_q & ~rst;
    assign dbg_state_o = state_q;

    always_comb begin
        merged = m_rdata;
        for (int n = 0; n < NB; n++) begin
            if (d_be[n]) merged[8*n +: 8] = d_wdata[8*n +: 8];
        end
    end

    // On a tie, the port that did not win last time gets the RAM.
    assign pick_i = i_req & (~d_req | last_d_q);
    assign pick_d = d_req & ~pick_i;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        m_en       = 1'b0;
        m_rd_en    = 1'b0;
        m_wr_en    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (pick_i) begin
                        m_en       = 1'b1;
                        m_rd_en    = 1'b1;
                        m_addr     = i_addr;
                        i_gnt      = 1'b1;
                        i_rvalid_d = 1'b1;
                        last_d_d   = 1'b0;
                    end else if (pick_d) begin
                        m_addr = d_addr;
                        if (!d_we) begin
                            m_en       = 1'b1;
                            m_rd_en    = 1'b1;
                            d_gnt      = 1'b1;
                            d_rvalid_d = 1'b1;
                            last_d_d   = 1'b1;
                        end else if (&d_be) begin
                            m_en     = 1'b1;
                            m_wr_en  = 1'b1;
                            m_wdata  = d_wdata;
                            d_gnt    = 1'b1;
                            last_d_d = 1'b1;
                        end else if (d_be == '0) begin
                            d_gnt    = 1'b1;
                            last_d_d = 1'b1;
                        end else begin
                            // Fetch the old word; the merge and write happen next cycle.
                            m_en    = 1'b1;
                            m_rd_en = 1'b1;
                            state_d = S_RMW;
                        end
                    end
                end
                S_RMW: begin
                    m_en     = 1'b1;
                    m_wr_en  = 1'b1;
                    m_addr   = d_addr;
                    m_wdata  = merged;
                    d_gnt    = 1'b1;
                    last_d_d = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_d_q   <= 1'b1;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed cycle table, a reset-during-RMW sequence,
// and random traffic checked against a transaction-level memory model.
module tb_bram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        m_en, m_rd_en, m_wr_en;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        dbg_state;

    // clock / reset
    always #5 clk = ~clk;

    bram_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .dbg_state_o(dbg_state)
    );

    // RAM behavioural model with a preload port for the bench
    logic [31:0] ram [0:16383];
    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (m_en) begin
            if (m_wr_en) ram[m_addr[13:0]] <= m_wdata;
            if (m_rd_en) m_rdata <= ram[m_addr[13:0]];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] dat);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = dat;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // driver: apply one cycle of inputs at the falling edge, settle, return
    task automatic drive(input logic r, input logic ir, input logic [15:0] ia,
                         input logic dr, input logic we, input logic [3:0] be,
                         input logic [15:0] da, input logic [31:0] wd);
        @(negedge clk);
        rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_be = be;
        d_addr = da; d_wdata = wd;
        #1;
    endtask

    typedef struct {
        logic        r, ir;
        logic [15:0] ia;
        logic        dr, we;
        logic [3:0]  be;
        logic [15:0] da;
        logic [31:0] wd;
        logic        eig, edg, emen, emwr;
        logic [15:0] emaddr;
        logic [31:0] emwdata;
        logic        eirv, edrv;
        logic [31:0] erdata;
    } vec_t;

    function automatic vec_t v(logic r, logic ir, logic [15:0] ia, logic dr, logic we,
                               logic [3:0] be, logic [15:0] da, logic [31:0] wd,
                               logic eig, logic edg, logic emen, logic emwr,
                               logic [15:0] emaddr, logic [31:0] emwdata,
                               logic eirv, logic edrv, logic [31:0] erdata);
        vec_t t;
        t.r = r; t.ir = ir; t.ia = ia; t.dr = dr; t.we = we; t.be = be; t.da = da; t.wd = wd;
        t.eig = eig; t.edg = edg; t.emen = emen; t.emwr = emwr; t.emaddr = emaddr;
        t.emwdata = emwdata; t.eirv = eirv; t.edrv = edrv; t.erdata = erdata;
        return t;
    endfunction

    vec_t tbl [27];

    // scoreboard for the random phase
    logic [31:0] ref_mem [0:15];
    logic [31:0] exp_q [$];

    initial begin
        logic [31:0] e, old, nw;
        logic        m_rmw, m_last_d, nxt_irv, nxt_drv, cur_irv, cur_drv, e_ig, e_dg;
        logic        i_got, d_got, win_i, win_d;
        logic [3:0]  rmw_be;
        logic [3:0]  rmw_addr;
        logic [31:0] rmw_wd;

        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(negedge clk);
        preload(14'h10, 32'hDEADBEEF);
        preload(14'h20, 32'hAABBCCDD);

        //        r  ir ia     dr we be    da     wd            ig dg en wr maddr  mwdata        irv drv rdata
        tbl[0]  = v(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 32'h0);
        tbl[1]  = v(0, 1, 16'h10,0, 0, 4'h0, 16'h0, 32'h0,        1, 0, 1, 0, 16'h10, 32'h0,        0, 0, 32'h0);
        tbl[2]  = v(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        1, 0, 32'hDEADBEEF);
        tbl[3]  = v(1, 1, 16'h10,1, 0, 4'h0, 16'h20,32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 32'h0);
        tbl[4]  = v(0, 1, 16'h10,1, 0, 4'h0, 16'h20,32'h0,        1, 0, 1, 0, 16'h10, 32'h0,        0, 0, 32'h0);
        tbl[5]  = v(0, 1, 16'h10,1, 0, 4'h0, 16'h20,32'h0,        0, 1, 1, 0, 16'h20, 32'h0,        1, 0, 32'hDEADBEEF);
        tbl[6]  = v(0, 1, 16'h10,1, 0, 4'h0, 16'h20,32'h0,        1, 0, 1, 0, 16'h10, 32'h0,        0, 1, 32'hAABBCCDD);
        tbl[7]  = v(0, 1, 16'h10,1, 0, 4'h0, 16'h20,32'h0,        0, 1, 1, 0, 16'h20, 32'h0,        1, 0, 32'hDEADBEEF);
        tbl[8]  = v(0, 1, 16'h10,1, 0, 4'h0, 16'h20,32'h0,        1, 0, 1, 0, 16'h10, 32'h0,        0, 1, 32'hAABBCCDD);
        tbl[9]  = v(0, 1, 16'h10,1, 0, 4'h0, 16'h20,32'h0,        0, 1, 1, 0, 16'h20, 32'h0,        1, 0, 32'hDEADBEEF);
        tbl[10] = v(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        0, 1, 32'hAABBCCDD);
        tbl[11] = v(0, 1, 16'h10,0, 0, 4'h0, 16'h0, 32'h0,        1, 0, 1, 0, 16'h10, 32'h0,        0, 0, 32'h0);
        tbl[12] = v(0, 1, 16'h10,1, 1, 4'h3, 16'h20,32'h00001234, 0, 0, 1, 0, 16'h20, 32'h0,        1, 0, 32'hDEADBEEF);
        tbl[13] = v(0, 1, 16'h10,1, 1, 4'h3, 16'h20,32'h00001234, 0, 1, 1, 1, 16'h20, 32'hAABB1234,  0, 0, 32'h0);
        tbl[14] = v(0, 1, 16'h10,0, 0, 4'h0, 16'h0, 32'h0,        1, 0, 1, 0, 16'h10, 32'h0,        0, 0, 32'h0);
        tbl[15] = v(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        1, 0, 32'hDEADBEEF);
        tbl[16] = v(0, 0, 16'h0, 1, 1, 4'hF, 16'h30,32'h12345678, 0, 1, 1, 1, 16'h30, 32'h12345678,  0, 0, 32'h0);
        tbl[17] = v(0, 0, 16'h0, 1, 0, 4'h0, 16'h30,32'h0,        0, 1, 1, 0, 16'h30, 32'h0,        0, 0, 32'h0);
        tbl[18] = v(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        0, 1, 32'h12345678);
        tbl[19] = v(0, 0, 16'h0, 1, 0, 4'h0, 16'h20,32'h0,        0, 1, 1, 0, 16'h20, 32'h0,        0, 0, 32'h0);
        tbl[20] = v(0, 0, 16'h0, 1, 1, 4'hF, 16'h20,32'h55667788, 0, 1, 1, 1, 16'h20, 32'h55667788,  0, 1, 32'hAABB1234);
        tbl[21] = v(0, 0, 16'h0, 1, 0, 4'h0, 16'h20,32'h0,        0, 1, 1, 0, 16'h20, 32'h0,        0, 0, 32'h0);
        tbl[22] = v(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        0, 1, 32'h55667788);
        tbl[23] = v(0, 0, 16'h0, 1, 1, 4'h0, 16'h20,32'hFFFFFFFF, 0, 1, 0, 0, 16'h0,  32'h0,        0, 0, 32'h0);
        tbl[24] = v(0, 1, 16'h20,1, 0, 4'h0, 16'h30,32'h0,        1, 0, 1, 0, 16'h20, 32'h0,        0, 0, 32'h0);
        tbl[25] = v(0, 1, 16'h20,1, 0, 4'h0, 16'h30,32'h0,        0, 1, 1, 0, 16'h30, 32'h0,        1, 0, 32'h55667788);
        tbl[26] = v(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0,        0, 0, 0, 0, 16'h0,  32'h0,        0, 1, 32'h12345678);

        for (int k = 0; k < 27; k++) begin
            drive(tbl[k].r, tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].we, tbl[k].be, tbl[k].da, tbl[k].wd);
            chk($sformatf("row%0d i_gnt", k), i_gnt, tbl[k].eig);
            chk($sformatf("row%0d d_gnt", k), d_gnt, tbl[k].edg);
            chk($sformatf("row%0d m_en", k), m_en, tbl[k].emen);
            chk($sformatf("row%0d m_wr_en", k), m_wr_en, tbl[k].emwr);
            chk($sformatf("row%0d i_rvalid", k), i_rvalid, tbl[k].eirv);
            chk($sformatf("row%0d d_rvalid", k), d_rvalid, tbl[k].edrv);
            if (tbl[k].emen) chk($sformatf("row%0d m_addr", k), m_addr, tbl[k].emaddr);
            if (tbl[k].emwr) chk($sformatf("row%0d m_wdata", k), m_wdata, tbl[k].emwdata);
            if (tbl[k].eirv) chk($sformatf("row%0d i_rdata", k), i_rdata, tbl[k].erdata);
            if (tbl[k].edrv) chk($sformatf("row%0d d_rdata", k), d_rdata, tbl[k].erdata);
        end
        chk("ram_0x20_after_empty_store", ram[14'h20], 32'h55667788);

        // reset landing in the RMW write cycle
        preload(14'h20, 32'hAABBCCDD);
        drive(0, 1, 16'h10, 0, 0, 4'h0, 16'h0, 32'h0);
        chk("rr_pre i_gnt", i_gnt, 1'b1);
        drive(0, 1, 16'h10, 1, 1, 4'h3, 16'h20, 32'h00001234);
        chk("rr_read d_gnt", d_gnt, 1'b0);
        chk("rr_read m_rd_en", m_rd_en, 1'b1);
        chk("rr_read rmw_state", dbg_state, 1'b0);
        drive(1, 1, 16'h10, 1, 1, 4'h3, 16'h20, 32'h00001234);
        chk("rr_rst m_wr_en", m_wr_en, 1'b0);
        chk("rr_rst m_en", m_en, 1'b0);
        chk("rr_rst d_gnt", d_gnt, 1'b0);
        chk("rr_rst i_gnt", i_gnt, 1'b0);
        chk("rr_rst rvalid", {i_rvalid, d_rvalid}, 2'b00);
        drive(0, 1, 16'h10, 1, 0, 4'h0, 16'h20, 32'h0);
        chk("rr_tie i_gnt", i_gnt, 1'b1);
        chk("rr_tie d_gnt", d_gnt, 1'b0);
        drive(0, 0, 16'h0, 1, 0, 4'h0, 16'h20, 32'h0);
        chk("rr_load d_gnt", d_gnt, 1'b1);
        drive(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
        chk("rr_load d_rvalid", d_rvalid, 1'b1);
        chk("rr_load d_rdata", d_rdata, 32'hAABBCCDD);
        chk("rr_ram_0x20", ram[14'h20], 32'hAABBCCDD);

        // random traffic against a memory/arbitration model
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            preload(14'(a), ref_mem[a]);
        end
        drive(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
        m_rmw = 0; m_last_d = 1; nxt_irv = 0; nxt_drv = 0; i_got = 1; d_got = 1;
        rmw_be = '0; rmw_addr = '0; rmw_wd = '0;
        exp_q.delete();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst = 1'b0;
            if (!i_req || i_got) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 16'($urandom_range(0, 15));
            end
            if (!d_req || d_got) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_be    = 4'($urandom_range(0, 15));
                d_addr  = 16'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            #1;
            cur_irv = nxt_irv; cur_drv = nxt_drv;
            nxt_irv = 0; nxt_drv = 0; e_ig = 0; e_dg = 0;
            if (cur_irv || cur_drv) begin
                if (exp_q.size() == 0) chk("rand exp_q underflow", 32'h1, 32'h0);
                else begin
                    e = exp_q.pop_front();
                    if (cur_irv) chk("rand i_rdata", i_rdata, e);
                    else chk("rand d_rdata", d_rdata, e);
                end
            end
            if (m_rmw) begin
                e_dg = 1; m_rmw = 0; m_last_d = 1;
                old = ref_mem[rmw_addr]; nw = old;
                for (int b = 0; b < 4; b++) if (rmw_be[b]) nw[8*b +: 8] = rmw_wd[8*b +: 8];
                ref_mem[rmw_addr] = nw;
            end else begin
                win_i = i_req && (!d_req || m_last_d);
                win_d = d_req && !win_i;
                if (win_i) begin
                    e_ig = 1; nxt_irv = 1; m_last_d = 0;
                    exp_q.push_back(ref_mem[i_addr[3:0]]);
                end else if (win_d) begin
                    if (!d_we) begin
                        e_dg = 1; nxt_drv = 1; m_last_d = 1;
                        exp_q.push_back(ref_mem[d_addr[3:0]]);
                    end else if (d_be == 4'hF) begin
                        e_dg = 1; m_last_d = 1; ref_mem[d_addr[3:0]] = d_wdata;
                    end else if (d_be == 4'h0) begin
                        e_dg = 1; m_last_d = 1;
                    end else begin
                        m_rmw = 1; rmw_be = d_be; rmw_addr = d_addr[3:0]; rmw_wd = d_wdata;
                    end
                end
            end
            chk("rand i_gnt", i_gnt, e_ig);
            chk("rand d_gnt", d_gnt, e_dg);
            chk("rand i_rvalid", i_rvalid, cur_irv);
            chk("rand d_rvalid", d_rvalid, cur_drv);
            i_got = e_ig; d_got = e_dg;
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
